gray_seq_counter: RTL and testbench
===================================

Name: gray_seq_counter

Overview:
- Registered Gray-code up/down counter. It produces the Gray-coded count that feeds the gray_to_binary decode stage directly downstream.
- A small control FSM supports free-running and one-shot (stop-at-terminal) modes, synchronous binary load, and a wrap pulse.
- Counting is done internally in binary. The Gray output is registered so that only one output bit changes per step.

Parameters:
- WIDTH, 4, count width in bits for both the Gray output and the internal binary register; minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin or resume counting.
- en  input  1  advance enable; counter steps only when en=1 in RUN.
- up_dn  input  1  1 = count up, 0 = count down; sampled per step.
- oneshot  input  1  1 = stop at terminal value, 0 = wrap freely; sampled per step.
- load  input  1  synchronous load request.
- load_bin  input  WIDTH  binary load value.
- gray_out  output  WIDTH  registered Gray code, equal to bin ^ (bin >> 1).
- wrap  output  1  one-cycle pulse when the count wraps.
- busy  output  1  high while the FSM is in RUN.
- done  output  1  high while the FSM is in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): bin=0, gray_out=0, wrap=0, busy=0, done=0, state=IDLE.
- Internal binary register bin[WIDTH-1:0]. gray_out is registered from the next value of bin, so gray_out always equals gray(bin) with no extra cycle of lag.
- Terminal value: all-ones when up_dn=1, zero when up_dn=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: hold the count. start=1 -> RUN.
  - RUN, en=1:
    - bin <= bin ± 1, modulo 2^WIDTH.
    - If oneshot=1 and bin equals the terminal value for the current up_dn: no step; state -> DONE.
    - If oneshot=0 and bin equals the terminal value: step wraps (max->0 up, 0->max down); wrap=1 for exactly that one cycle, coincident with gray_out showing the wrapped value.
  - RUN, en=0: hold; no wrap.
  - DONE: hold the count. start=1 -> RUN; the next en step wraps and pulses wrap (oneshot is re-evaluated only after the value leaves terminal).
- load=1 has the highest priority in any state:
  - bin <= load_bin; gray_out shows gray(load_bin) on the next edge.
  - No step and no wrap that cycle.
  - DONE -> IDLE; IDLE and RUN unchanged.
- load and start together: load applies, and start is also honoured (IDLE/DONE -> RUN).
- busy = (state==RUN); done = (state==DONE). Both are registered and reflect the state after the edge.
- Latency: one clock from a sampled en, load, or start to the updated gray_out and flags.
- up_dn may change on any cycle; it takes effect on the next step. No glitch-free guarantee is given on the inputs.
- Reset asserted mid-count returns immediately to the reset values; no partial step completes.

Optional Feature:
- Macro GRAY_SEQ_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, reset 0).
  - Adds a register holding the previous gray_out.
  - chk_err is set sticky when a cycle without load shows a popcount(gray_out ^ prev) other than 0 or 1.
  - chk_err is cleared only by reset or load.
- Not defined: no chk_err port and no extra logic.

Test Plan:
- Reset with rst_n=0 mid-RUN: gray_out=0000, wrap=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Free-run up (WIDTH=4, start, en=1, up_dn=1, oneshot=0) over 17 steps:
  - gray_out sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000,0001.
  - wrap=1 only on the 0000 cycle.
- Down from reset (start, en=1, up_dn=0, oneshot=0): first step gray_out=1000 (bin 15) with wrap=1; next step 1001 (bin 14).
- One-shot up from load_bin=13 (gray 1011):
  - Steps give 1001, then 1000 (bin 15).
  - Next en cycle: no change, done=1, busy=0.
  - start, then en: gray_out=0000 with wrap=1.
- Load priority: in RUN with en=1, load=1, load_bin=5 -> gray_out=0111, no wrap; load in DONE -> IDLE, done=0.
- With GRAY_SEQ_CHECK_EN: over a full 32-step up/down sweep with a direction flip, chk_err stays 0; load does not set it.

Source files
------------

// File: rtl/gray_seq_counter.sv
// rtl/gray_seq_counter.sv - registered Gray-code up/down counter with IDLE/RUN/DONE control
// Optional build macro: GRAY_SEQ_CHECK_EN (adds chk_err single-step Gray monitor)
module gray_seq_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             en,
   input  logic             up_dn,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] gray_out,
`ifdef GRAY_SEQ_CHECK_EN
   output logic             chk_err,
`endif
   output logic             wrap,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic             busy_q, done_q;
   // Set on DONE->RUN so the first step off the terminal value wraps instead of re-stopping
   logic             resume_q, resume_d;

   logic             at_term;
   logic [WIDTH-1:0] bin_step;

   // Terminal value depends on the direction sampled this cycle
   always_comb begin
      at_term  = up_dn ? (bin_q == {WIDTH{1'b1}}) : (bin_q == {WIDTH{1'b0}});
      bin_step = up_dn ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
   end

   // Next-state and next-count decode; load overrides everything, start still honoured with it
   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      wrap_d   = 1'b0;
      resume_d = resume_q;
      if (load) begin
         bin_d    = load_bin;
         resume_d = 1'b0;
         if (start) begin
            state_d = ST_RUN;
         end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (en) begin
                  if (at_term && oneshot && !resume_q) begin
                     state_d = ST_DONE;
                  end else begin
                     bin_d    = bin_step;
                     wrap_d   = at_term;
                     resume_d = 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_d  = ST_RUN;
                  resume_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   // State, count and all flags registered together so outputs reflect the post-edge state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         bin_q    <= '0;
         gray_q   <= '0;
         wrap_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         resume_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         gray_q   <= gray_d;
         wrap_q   <= wrap_d;
         busy_q   <= (state_d == ST_RUN);
         done_q   <= (state_d == ST_DONE);
         resume_q <= resume_d;
      end
   end

   assign gray_out = gray_q;
   assign wrap     = wrap_q;
   assign busy     = busy_q;
   assign done     = done_q;

`ifdef GRAY_SEQ_CHECK_EN
   logic [WIDTH-1:0] prev_q;
   logic             skip_q;
   logic             chk_err_q;
   logic [WIDTH-1:0] diff;
   logic             multi_bit;

   // More than one bit set iff clearing the lowest set bit leaves something behind
   always_comb begin
      diff      = gray_q ^ prev_q;
      multi_bit = |(diff & (diff - WIDTH'(1)));
   end

   // Sticky monitor; the cycle right after a load is exempt since a jump is expected there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q    <= '0;
         skip_q    <= 1'b0;
         chk_err_q <= 1'b0;
      end else begin
         prev_q <= gray_q;
         skip_q <= load;
         if (load) begin
            chk_err_q <= 1'b0;
         end else if (!skip_q && multi_bit) begin
            chk_err_q <= 1'b1;
         end
      end
   end

   assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_gray_seq_counter.sv
// tb/tb_gray_seq_counter.sv - table-driven self-checking bench for gray_seq_counter
module tb_gray_seq_counter;

   logic       clk;
   logic       rst_n;
   logic       start, en, up_dn, oneshot, load;
   logic [3:0] load_bin;
   logic [3:0] gray_out;
   logic       wrap, busy, done;
`ifdef GRAY_SEQ_CHECK_EN
   logic       chk_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   gray_seq_counter #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .en       (en),
      .up_dn    (up_dn),
      .oneshot  (oneshot),
      .load     (load),
      .load_bin (load_bin),
      .gray_out (gray_out),
`ifdef GRAY_SEQ_CHECK_EN
      .chk_err  (chk_err),
`endif
      .wrap     (wrap),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start, en, up_dn, oneshot, load;
      logic [3:0] lb;
      logic [3:0] g;
      logic       w, b, d;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s, logic e, logic u, logic o, logic l, logic [3:0] lb,
                               logic [3:0] g, logic w, logic b, logic d);
      vec_t v;
      v.start = s; v.en = e; v.up_dn = u; v.oneshot = o; v.load = l; v.lb = lb;
      v.g = g; v.w = w; v.b = b; v.d = d;
      return v;
   endfunction

   task automatic check(string name, logic [3:0] g, logic w, logic b, logic d);
      n_checks++;
      if (gray_out === g && wrap === w && busy === b && done === d) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got gray=%b wrap=%b busy=%b done=%b, want gray=%b wrap=%b busy=%b done=%b",
                  name, gray_out, wrap, busy, done, g, w, b, d);
      end
   endtask

   task automatic apply(vec_t v);
      @(negedge clk);
      start = v.start; en = v.en; up_dn = v.up_dn; oneshot = v.oneshot;
      load = v.load; load_bin = v.lb;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] up_seq [17];

   initial begin
      up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000,
                 4'b0001};

      // start, then 17 free-running up steps
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 0));
      for (int i = 0; i < 17; i++) begin
         vecs.push_back(mk(0, 1, 1, 0, 0, 0, up_seq[i], (i == 15), 1, 0));
      end
      // load priority over a step in RUN
      vecs.push_back(mk(0, 1, 1, 0, 1, 4'd5,  4'b0111, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0,     4'b0110, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,     4'b0110, 0, 1, 0));
      // one-shot up from 13
      vecs.push_back(mk(0, 0, 1, 1, 1, 4'd13, 4'b1011, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0,     4'b1001, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0,     4'b1000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0,     4'b1000, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0,     4'b1000, 0, 0, 1));
      // resume from DONE: first step wraps despite oneshot
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,     4'b1000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0,     4'b0000, 1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0,     4'b0001, 0, 1, 0));
      // one-shot down to zero terminal
      vecs.push_back(mk(0, 1, 0, 1, 0, 0,     4'b0000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0,     4'b0000, 0, 0, 1));
      // load in DONE -> IDLE; load+start -> RUN
      vecs.push_back(mk(0, 0, 0, 0, 1, 4'd5,  4'b0111, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0,     4'b0111, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 1, 4'd2,  4'b0011, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0,     4'b0011, 0, 1, 0));

      rst_n = 1'b0; start = 0; en = 0; up_dn = 1; oneshot = 0; load = 0; load_bin = 0;
      #12;
      check("reset", 4'b0000, 0, 0, 0);
`ifdef GRAY_SEQ_CHECK_EN
      n_checks++;
      if (chk_err === 1'b0) n_pass++;
      else $display("FAIL chk_reset: got chk_err=%b want 0", chk_err);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i]);
         check($sformatf("vec%0d", i), vecs[i].g, vecs[i].w, vecs[i].b, vecs[i].d);
      end

      // asynchronous reset mid-RUN, observed before any clock edge
      apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 4'b0000, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // down from reset: wraps to 15 immediately, then 14
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("down_start", 4'b0000, 0, 1, 0);
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      check("down_wrap", 4'b1000, 1, 1, 0);
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      check("down_14", 4'b1001, 0, 1, 0);

`ifdef GRAY_SEQ_CHECK_EN
      // 32-step sweep with a direction flip, plus a load mid-way
      for (int i = 0; i < 32; i++) begin
         apply(mk(0, 1, (i < 16), 0, (i == 20), 4'd9, 0, 0, 0, 0));
      end
      n_checks++;
      if (chk_err === 1'b0) n_pass++;
      else $display("FAIL chk_sweep: got chk_err=%b want 0", chk_err);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
